// File: rtl/cma_seq_pkg.sv
// Shared definitions for the CMA sequencing controller.
// Contents:
//   state_t   - controller state encoding (IDLE, LOAD, EXEC, FIN)
//   DBG_*     - debug-select codes for the DBGSEL/DBGDAT observation port
//   idx_w()   - index width for a power-of-two count, never narrower than 1 bit
package cma_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [2:0] DBG_STATE = 3'd0;
  localparam logic [2:0] DBG_BANK  = 3'd1;
  localparam logic [2:0] DBG_WCNT  = 3'd2;
  localparam logic [2:0] DBG_CCNT  = 3'd3;
  localparam logic [2:0] DBG_FLAGS = 3'd4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cma_conf_bank.sv
// Banked configuration store: NBANK x DEPTH words of DW bits held in registers.
// Ports:
//   clk      - clock
//   we       - write enable (already qualified by the controller)
//   waddr    - write address {bank, word}
//   wdata    - write data
//   raddr_a  - loader read address {bank, word}, combinational read on rdata_a
//   raddr_b  - host read address {bank, word}, combinational read on rdata_b
// Contents are intentionally not reset.
module cma_conf_bank
  import cma_seq_pkg::*;
#(
  parameter int DW    = 25,
  parameter int NBANK = 2,
  parameter int DEPTH = 64,
  localparam int AW   = idx_w(NBANK) + idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/cma_seq_ctrl.sv
// CMA run controller: owns the banked configuration store, streams the
// selected bank to the PE array over a ready/valid channel, then enables the
// array for a programmed number of cycles and pulses DONE.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   EXWE/EXRE/EXA/EXWD  - host write/read strobes, {bank,word} address, write data
//   EXRD/EXRVALID       - registered host read data and its one-cycle valid
//   CBANK/NWORDS/RUN_CYCLES - job description, sampled when RUN is accepted
//   RUN/ABORT           - start and abort requests
//   CONF_VALID/CONF_READY/CONF_ADDR/CONF_WORD - configuration stream to the array
//   ARRAY_EN            - PE array run enable
//   BUSY/DONE/WERR      - not-idle, completion pulse, sticky write-conflict flag
//   DBGSEL/DBGDAT       - debug observation mux
module cma_seq_ctrl
  import cma_seq_pkg::*;
#(
  parameter int DW    = 25,
  parameter int NBANK = 2,
  parameter int DEPTH = 64,
  parameter int CYC_W = 16,
  parameter int DBG_W = 4,
  localparam int BW   = idx_w(NBANK),
  localparam int WW   = idx_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EXWE,
  input  logic             EXRE,
  input  logic [BW+WW-1:0] EXA,
  input  logic [DW-1:0]    EXWD,
  output logic [DW-1:0]    EXRD,
  output logic             EXRVALID,
  input  logic [BW-1:0]    CBANK,
  input  logic             RUN,
  input  logic             ABORT,
  input  logic [WW:0]      NWORDS,
  input  logic [CYC_W-1:0] RUN_CYCLES,
  output logic             CONF_VALID,
  input  logic             CONF_READY,
  output logic [WW-1:0]    CONF_ADDR,
  output logic [DW-1:0]    CONF_WORD,
  output logic             ARRAY_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             WERR,
  input  logic [2:0]       DBGSEL,
  output logic [DBG_W-1:0] DBGDAT
);

  state_t state_q, state_d;

  logic [BW-1:0]    act_bank;
  logic [BW-1:0]    loaded_bank;
  logic             loaded_valid;
  logic             werr;
  logic [WW:0]      wcnt;
  logic [WW:0]      nwords;
  logic [CYC_W-1:0] cyc;

  logic             start;
  logic             beat;
  logic             last_beat;
  logic [BW-1:0]    host_bank;
  logic             wr_conflict;
  logic             wr_en;
  logic             rd_en;
  logic [DW-1:0]    load_word;
  logic [DW-1:0]    host_word;
  logic [31:0]      dbg_full;

  assign host_bank   = EXA[BW+WW-1:WW];
  // The bank being streamed must not change under the loader.
  assign wr_conflict = EXWE && (state_q == ST_LOAD) && (host_bank == act_bank);
  assign wr_en       = EXWE && !wr_conflict;
  // A simultaneous write takes the port; the read is dropped.
  assign rd_en       = EXRE && !EXWE;

  cma_conf_bank #(
    .DW    (DW),
    .NBANK (NBANK),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk     (CLK),
    .we      (wr_en),
    .waddr   (EXA),
    .wdata   (EXWD),
    .raddr_a ({act_bank, wcnt[WW-1:0]}),
    .rdata_a (load_word),
    .raddr_b (EXA),
    .rdata_b (host_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    CONF_VALID = 1'b0;
    CONF_ADDR  = '0;
    CONF_WORD  = '0;
    ARRAY_EN   = 1'b0;
    DONE       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // RUN takes precedence over a coincident ABORT here.
        if (RUN) begin
          start = 1'b1;
          if ((NWORDS == '0) || (loaded_valid && (loaded_bank == CBANK))) state_d = ST_EXEC;
          else                                                           state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        CONF_VALID = 1'b1;
        CONF_ADDR  = wcnt[WW-1:0];
        CONF_WORD  = load_word;
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (CONF_READY) begin
          beat = 1'b1;
          if ((wcnt + (WW+1)'(1)) == nwords) begin
            last_beat = 1'b1;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Enable stays up through an abort cycle and drops on the next one.
        ARRAY_EN = (cyc != '0);
        if (ABORT)                          state_d = ST_IDLE;
        else if (cyc <= CYC_W'(1))          state_d = ST_FIN;
      end
      ST_FIN: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      act_bank     <= '0;
      loaded_bank  <= '0;
      loaded_valid <= 1'b0;
      werr         <= 1'b0;
      wcnt         <= '0;
      nwords       <= '0;
      cyc          <= '0;
      EXRD         <= '0;
      EXRVALID     <= 1'b0;
    end else begin
      EXRVALID <= rd_en;
      if (rd_en) EXRD <= host_word;

      if (wr_conflict) werr <= 1'b1;

      if (start) begin
        act_bank <= CBANK;
        nwords   <= NWORDS;
        cyc      <= RUN_CYCLES;
        wcnt     <= '0;
      end
      if (beat) wcnt <= wcnt + (WW+1)'(1);
      if (ARRAY_EN) cyc <= cyc - CYC_W'(1);

      // An interrupted load leaves the array holding a partial image.
      if (last_beat) begin
        loaded_bank  <= act_bank;
        loaded_valid <= 1'b1;
      end else if ((state_q == ST_LOAD) && ABORT) begin
        loaded_valid <= 1'b0;
      end else if (wr_en && (state_q != ST_LOAD) && (host_bank == loaded_bank)) begin
        loaded_valid <= 1'b0;
      end
    end
  end

  assign BUSY = (state_q != ST_IDLE);
  assign WERR = werr;

  always_comb begin
    dbg_full = '0;
    case (DBGSEL)
      DBG_STATE: dbg_full = 32'(state_q);
      DBG_BANK:  dbg_full = 32'(act_bank);
      DBG_WCNT:  dbg_full = 32'(wcnt);
      DBG_CCNT:  dbg_full = 32'(cyc);
      DBG_FLAGS: dbg_full = {28'd0, werr, loaded_valid, BUSY, DONE};
      default:   dbg_full = '0;
    endcase
  end

  assign DBGDAT = dbg_full[DBG_W-1:0];

endmodule

// File: tb/tb_cma_seq_ctrl.sv
module tb_cma_seq_ctrl;

  localparam int DW = 25, NBANK = 2, DEPTH = 64, CYC_W = 16, DBG_W = 4;
  localparam int BW = 1, WW = 6, AW = BW + WW;

  logic             CLK = 1'b0;
  logic             RST, EXWE, EXRE, RUN, ABORT, CONF_READY;
  logic [AW-1:0]    EXA;
  logic [DW-1:0]    EXWD, EXRD, CONF_WORD;
  logic             EXRVALID, CONF_VALID, ARRAY_EN, BUSY, DONE, WERR;
  logic [BW-1:0]    CBANK;
  logic [WW:0]      NWORDS;
  logic [CYC_W-1:0] RUN_CYCLES;
  logic [WW-1:0]    CONF_ADDR;
  logic [2:0]       DBGSEL;
  logic [DBG_W-1:0] DBGDAT;

  always #5 CLK = ~CLK;

  cma_seq_ctrl #(.DW(DW), .NBANK(NBANK), .DEPTH(DEPTH), .CYC_W(CYC_W), .DBG_W(DBG_W)) dut (
    .CLK(CLK), .RST(RST), .EXWE(EXWE), .EXRE(EXRE), .EXA(EXA), .EXWD(EXWD),
    .EXRD(EXRD), .EXRVALID(EXRVALID), .CBANK(CBANK), .RUN(RUN), .ABORT(ABORT),
    .NWORDS(NWORDS), .RUN_CYCLES(RUN_CYCLES), .CONF_VALID(CONF_VALID),
    .CONF_READY(CONF_READY), .CONF_ADDR(CONF_ADDR), .CONF_WORD(CONF_WORD),
    .ARRAY_EN(ARRAY_EN), .BUSY(BUSY), .DONE(DONE), .WERR(WERR),
    .DBGSEL(DBGSEL), .DBGDAT(DBGDAT)
  );

  int n_pass = 0, n_tot = 0;

  typedef struct { int addr; logic [DW-1:0] word; } beat_t;
  typedef struct { int beats; int en; } done_t;
  typedef struct { int cyc; int addr; logic [DW-1:0] data; } pw_t;

  beat_t         conf_q[$];
  done_t         done_q[$];
  logic [DW-1:0] rd_q[$];
  pw_t           pend_w[$];

  // Reference model state
  logic [DW-1:0] mmem [NBANK*DEPTH];
  bit m_lv = 0, m_werr = 0;
  int m_lb = 0, m_last_bank = 0, m_wcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor / scoreboard
  initial begin : mon
    beat_t b;
    done_t d;
    logic [DW-1:0] e;
    int beats_seen, en_seen;
    bit prev_stall;
    logic [WW-1:0] prev_addr;
    logic [DW-1:0] prev_word;
    beats_seen = 0; en_seen = 0; prev_stall = 0;
    prev_addr = '0; prev_word = '0;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0) begin
        prev_stall = 0;
      end else begin
        if (EXRVALID) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
          else begin e = rd_q.pop_front(); chk("exrd", 64'(EXRD), 64'(e)); end
        end
        if (CONF_VALID) begin
          if (prev_stall) begin
            chk("stall_addr", 64'(CONF_ADDR), 64'(prev_addr));
            chk("stall_word", 64'(CONF_WORD), 64'(prev_word));
          end
          if (CONF_READY) begin
            if (conf_q.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
            else begin
              b = conf_q.pop_front();
              chk("conf_addr", 64'(CONF_ADDR), 64'(b.addr));
              chk("conf_word", 64'(CONF_WORD), 64'(b.word));
            end
            beats_seen++;
          end
          prev_stall = !CONF_READY;
          prev_addr  = CONF_ADDR;
          prev_word  = CONF_WORD;
        end else begin
          prev_stall = 0;
        end
        if (ARRAY_EN) en_seen++;
        if (DONE) begin
          if (done_q.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
          else begin
            d = done_q.pop_front();
            chk("job_beats", 64'(beats_seen), 64'(d.beats));
            chk("job_en_cycles", 64'(en_seen), 64'(d.en));
          end
        end
        if (!BUSY) begin beats_seen = 0; en_seen = 0; end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic host_write(input int addr, input logic [DW-1:0] data);
    EXWE = 1'b1; EXA = AW'(addr); EXWD = data;
    tick();
    EXWE = 1'b0;
    mmem[addr] = data;
    if (m_lv && (addr / DEPTH) == m_lb) m_lv = 0;
  endtask

  task automatic host_read(input int addr);
    EXRE = 1'b1; EXA = AW'(addr);
    rd_q.push_back(mmem[addr]);
    tick();
    EXRE = 1'b0;
  endtask

  task automatic check_dbg(input logic [2:0] sel, input logic [DBG_W-1:0] exp, input string nm);
    DBGSEL = sel;
    @(negedge CLK);
    chk(nm, 64'(DBGDAT), 64'(exp));
    tick();
    DBGSEL = 3'd0;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1 then ready.
  // abort_at>0 interrupts the job in cycle RUN+abort_at, by ABORT or (rst_mode) by RST.
  task automatic run_job(input int bank, input int nw, input int rc,
                         input int rdy_mode, input int abort_at, input bit rst_mode);
    bit pat[$];
    bit r, skip, aborted;
    int ones, idx, L, exp_lat, got, wb;
    bit inload;
    pat.delete(); ones = 0; idx = 0;
    while (ones < nw) begin
      if (rdy_mode == 0)      r = 1;
      else if (rdy_mode == 2) r = (idx < 4) ? (idx == 0 || idx == 3) : 1'b1;
      else                    r = ($urandom_range(0, 3) != 0);
      pat.push_back(r); ones += int'(r); idx++;
    end
    skip    = (nw == 0) || (m_lv && m_lb == bank);
    L       = skip ? 0 : pat.size();
    exp_lat = L + ((rc == 0) ? 1 : rc) + 1;
    aborted = (abort_at > 0) && (abort_at < exp_lat);
    if (!skip) for (int i = 0; i < nw; i++) conf_q.push_back('{i, mmem[bank*DEPTH + i]});
    if (!aborted) done_q.push_back('{skip ? 0 : nw, rc});

    m_last_bank = bank;
    if (aborted && rst_mode) begin
      m_lv = 0; m_lb = 0; m_werr = 0; m_last_bank = 0; m_wcnt = 0;
    end else begin
      if (!skip && !(aborted && abort_at <= L)) begin m_lv = 1; m_lb = bank; end
      else if (!skip) m_lv = 0;
      if (!aborted) m_wcnt = skip ? 0 : nw;
    end
    foreach (pend_w[j]) begin
      wb = pend_w[j].addr / DEPTH;
      inload = !skip && (pend_w[j].cyc <= L);
      if (inload && wb == bank) m_werr = 1;
      else begin
        mmem[pend_w[j].addr] = pend_w[j].data;
        if (!inload && m_lv && wb == m_lb) m_lv = 0;
      end
    end

    CBANK = BW'(bank); NWORDS = (WW+1)'(nw); RUN_CYCLES = CYC_W'(rc); RUN = 1'b1;
    tick();
    RUN = 1'b0;
    got = 0;
    for (int k = 1; k <= 300; k++) begin
      CONF_READY = (k - 1 < pat.size()) ? pat[k-1] : 1'($urandom_range(0, 1));
      ABORT = !rst_mode && (k == abort_at);
      RST   = rst_mode && (k == abort_at);
      EXWE  = 1'b0;
      foreach (pend_w[j]) if (pend_w[j].cyc == k) begin
        EXWE = 1'b1; EXA = AW'(pend_w[j].addr); EXWD = pend_w[j].data;
      end
      @(negedge CLK);
      if (k == 1) begin
        chk("first_conf_valid", 64'(CONF_VALID), 64'(!skip));
        chk("first_array_en", 64'(ARRAY_EN), 64'(skip && rc > 0));
      end
      if (DONE && got == 0) got = k;
      if (aborted && k == abort_at + 1) begin
        chk("abort_array_en", 64'(ARRAY_EN), 64'(0));
        chk("abort_conf_valid", 64'(CONF_VALID), 64'(0));
        chk("abort_busy", 64'(BUSY), 64'(0));
        if (rst_mode) begin
          chk("rst_werr", 64'(WERR), 64'(0));
          chk("rst_exrvalid", 64'(EXRVALID), 64'(0));
          chk("rst_exrd", 64'(EXRD), 64'(0));
          chk("rst_dbg", 64'(DBGDAT), 64'(0));
          chk("rst_conf_word", 64'(CONF_WORD), 64'(0));
        end
      end
      tick();
      ABORT = 1'b0; RST = 1'b0; EXWE = 1'b0;
      if (got != 0) break;
      if (aborted && k == abort_at + 4) break;
    end
    pend_w.delete();
    if (aborted) begin
      chk("no_done_after_abort", 64'(got), 64'(0));
      conf_q.delete();
    end else begin
      chk("done_latency", 64'(got), 64'(exp_lat));
    end
  endtask

  initial begin : drive
    int a;
    RST = 1'b1; EXWE = 0; EXRE = 0; EXA = '0; EXWD = '0; RUN = 0; ABORT = 0;
    CBANK = '0; NWORDS = '0; RUN_CYCLES = '0; CONF_READY = 0; DBGSEL = 3'd0;
    repeat (3) tick();
    @(negedge CLK);
    chk("reset_busy", 64'(BUSY), 64'(0));
    chk("reset_conf_valid", 64'(CONF_VALID), 64'(0));
    chk("reset_array_en", 64'(ARRAY_EN), 64'(0));
    chk("reset_done", 64'(DONE), 64'(0));
    chk("reset_werr", 64'(WERR), 64'(0));
    chk("reset_exrvalid", 64'(EXRVALID), 64'(0));
    chk("reset_exrd", 64'(EXRD), 64'(0));
    chk("reset_conf_addr", 64'(CONF_ADDR), 64'(0));
    chk("reset_dbg", 64'(DBGDAT), 64'(0));
    tick();
    RST = 1'b0;
    check_dbg(3'd4, 4'b0000, "reset_dbg_flags");

    for (int i = 0; i < NBANK*DEPTH; i++) host_write(i, DW'($urandom));
    for (int i = 0; i < 4; i++) host_write(i, DW'(32'h100000 + i));

    // Full load, then reload skip, then reload after a modification
    run_job(0, 4, 5, 0, 0, 0);
    run_job(0, 4, 5, 0, 0, 0);
    host_write(2, DW'(32'h0ABCDE));
    run_job(0, 4, 3, 0, 0, 0);

    // Back-pressure during load
    run_job(1, 4, 1, 2, 0, 0);

    // Write conflict on the bank being loaded; other bank still writable
    host_write(DEPTH + 7, DW'(32'h12345));
    pend_w.push_back('{2, DEPTH + 5, DW'(32'h1ABCDE)});
    pend_w.push_back('{3, 9, DW'(32'h0F0F0F)});
    run_job(1, 8, 2, 0, 0, 0);
    @(negedge CLK);
    chk("werr_set", 64'(WERR), 64'(m_werr));
    tick();
    host_read(DEPTH + 5);
    host_read(9);
    check_dbg(3'd4, {m_werr, m_lv, 2'b00}, "dbg_flags_after_werr");

    // Abort on the third EXEC cycle of a skipped-load job; loaded image kept
    run_job(1, 8, 10, 0, 3, 0);
    run_job(1, 8, 1, 0, 0, 0);
    @(negedge CLK);
    chk("werr_sticky", 64'(WERR), 64'(1));
    tick();

    // Reset in the middle of a load, then the same bank must reload
    run_job(0, 8, 1, 0, 3, 1);
    run_job(0, 8, 1, 0, 0, 0);

    // Nothing to load and nothing to run
    run_job(0, 0, 0, 0, 0, 0);

    // Simultaneous write and read
    EXWE = 1'b1; EXRE = 1'b1; EXA = AW'(DEPTH + 3); EXWD = DW'(32'h155AA5);
    tick();
    EXWE = 1'b0; EXRE = 1'b0;
    mmem[DEPTH + 3] = DW'(32'h155AA5);
    if (m_lv && m_lb == 1) m_lv = 0;
    @(negedge CLK);
    chk("wr_rd_same_cycle_rvalid", 64'(EXRVALID), 64'(0));
    tick();
    host_read(DEPTH + 3);

    // Randomized jobs with host traffic in between
    for (int j = 0; j < 25; j++) begin
      int nops;
      nops = $urandom_range(0, 3);
      for (int q = 0; q < nops; q++) begin
        a = $urandom_range(0, 1) * DEPTH + $urandom_range(0, 15);
        if ($urandom_range(0, 1) != 0) host_write(a, DW'($urandom));
        else host_read(a);
      end
      run_job($urandom_range(0, 1), $urandom_range(0, 10), $urandom_range(0, 6), 1, 0, 0);
      if (j % 6 == 0) begin
        check_dbg(3'd1, DBG_W'(m_last_bank), "dbg_bank");
        check_dbg(3'd2, DBG_W'(m_wcnt), "dbg_wcnt");
        check_dbg(3'd3, 4'd0, "dbg_ccnt");
        check_dbg(3'd4, {m_werr, m_lv, 2'b00}, "dbg_flags");
        check_dbg(3'd6, 4'd0, "dbg_unused");
      end
    end

    repeat (4) tick();
    chk("conf_q_drained", 64'(conf_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    chk("done_q_drained", 64'(done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cma_seq_ctrl.md
Name: cma_seq_ctrl

Overview:
- Parametrised successor to the CMA run controller: owns NBANK banked configuration stores written by the host, streams the selected bank into the PE array, then runs the array for a programmed cycle count and raises DONE.
- Adds over the previous generation:
  - arbitrary bank count;
  - a ready/valid configuration stream;
  - skipping the reload when the bank is already loaded and unmodified;
  - abort;
  - a sticky write-conflict error.
- Sits between the host bus (EXWE/EXRE/EXA/EXWD/EXRD) and the PE array configuration/enable inputs.

Parameters:
- DW, 25, host and configuration word width
- NBANK, 2, number of configuration banks (power of two, at least 2)
- DEPTH, 64, words per bank (power of two)
- CYC_W, 16, width of the run-cycle counter
- DBG_W, 4, debug output width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-high
- EXWE  in  1  host write strobe
- EXRE  in  1  host read strobe
- EXA  in  BW+WW  host address = {bank, word}; BW=clog2(NBANK), WW=clog2(DEPTH)
- EXWD  in  DW  host write data
- EXRD  out  DW  host read data, registered
- EXRVALID  out  1  EXRD valid, one-cycle pulse
- CBANK  in  BW  bank to execute, sampled on an accepted RUN
- RUN  in  1  start request
- ABORT  in  1  abort request
- NWORDS  in  WW+1  words to load (0..DEPTH), sampled on an accepted RUN
- RUN_CYCLES  in  CYC_W  execution length, sampled on an accepted RUN
- CONF_VALID  out  1  configuration word valid
- CONF_READY  in  1  array accepts the word
- CONF_ADDR  out  WW  word index
- CONF_WORD  out  DW  configuration data
- ARRAY_EN  out  1  PE array run enable
- BUSY  out  1  state is not IDLE
- DONE  out  1  one-cycle completion pulse
- WERR  out  1  sticky write-conflict flag
- DBGSEL  in  3  debug select
- DBGDAT  out  DBG_W  debug data

Behaviour:
- Reset values: all outputs 0, state IDLE, loaded_valid=0, WERR=0. Memory contents are not reset.
- Reset mid-operation: same result as power-up reset. No DONE is issued.
- Storage: NBANK×DEPTH×DW register array, one host write port, read combinationally by the loader and by the host.
- Host write: EXWE at edge t updates mem[EXA] at t+1.
- Host read: EXRE at t gives EXRD=mem[EXA] and EXRVALID=1 at t+1.
- EXWE and EXRE in the same cycle: the write is performed, the read is dropped, EXRVALID stays 0.
- A write to the bank currently in LOAD is discarded and sets WERR. WERR clears only on reset.
- A write to the loaded bank outside LOAD clears loaded_valid.
- FSM states: IDLE, LOAD, EXEC, FIN.
  - IDLE: RUN=1 samples CBANK, NWORDS and RUN_CYCLES and clears the word counter.
    - Go to EXEC if NWORDS=0, or if loaded_valid=1 and loaded_bank==CBANK.
    - Otherwise go to LOAD.
  - LOAD: CONF_VALID=1, CONF_ADDR=word counter, CONF_WORD=mem[bank][word counter].
    - A beat completes on CONF_VALID&CONF_READY and the counter increments.
    - After the beat on word NWORDS-1: set loaded_bank and loaded_valid=1, then go to EXEC.
    - The word must hold stable while READY is low.
  - EXEC: ARRAY_EN=1 for exactly RUN_CYCLES cycles, counted down. RUN_CYCLES=0 goes straight to FIN with no ARRAY_EN.
  - FIN: DONE=1 for one cycle, then IDLE.
- RUN outside IDLE is ignored.
- ABORT in any non-IDLE state: next state IDLE, CONF_VALID and ARRAY_EN deassert next cycle, no DONE.
  - An aborted LOAD clears loaded_valid.
  - An aborted EXEC keeps it.
- ABORT and RUN together in IDLE: RUN wins, ABORT is ignored.
- Latency: RUN at t gives CONF_VALID at t+1. Reload-skip gives ARRAY_EN at t+1.
- DBGSEL mapping, zero-extended or truncated to DBG_W:
  - 0: state
  - 1: active bank
  - 2: word counter LSBs
  - 3: cycle counter LSBs
  - 4: {WERR, loaded_valid, BUSY, DONE}
  - 5–7: 0

Decomposition:
- Package cma_seq_pkg holds:
  - the state enum;
  - DBGSEL code constants;
  - clog2-derived localparam helpers.
- One sub-module, cma_conf_bank: the banked register array with a write port and two combinational read ports.
- FSM and counters stay in the top module.

Test Plan:
- Write bank0 words 0..3 = 0x100000+i. RUN with CBANK=0, NWORDS=4, RUN_CYCLES=5, CONF_READY=1 → 4 beats with CONF_WORD 0x100000..0x100003, then ARRAY_EN high 5 cycles, then DONE pulse. Total RUN-to-DONE = 10 cycles.
- Repeat RUN with CBANK=0 and no intervening writes → no CONF_VALID, ARRAY_EN at t+1. Write bank0 word 2, RUN again → full reload occurs.
- Toggle CONF_READY 1,0,0,1 during LOAD → CONF_ADDR and CONF_WORD held while stalled, no word skipped or duplicated.
- During LOAD of bank1, EXWE to {1,5} → memory unchanged, WERR=1 and stays set. EXWE to bank0 in the same period succeeds.
- ABORT on the 3rd EXEC cycle of RUN_CYCLES=10 → ARRAY_EN low next cycle, BUSY=0, no DONE. RST asserted mid-LOAD → all outputs 0, and the next RUN to the same bank reloads.
- Edge cases: NWORDS=0 with RUN_CYCLES=0 → DONE at t+2. Simultaneous EXWE+EXRE → EXRVALID=0 and the write lands. DBGSEL=4 in IDLE after the WERR test → 4'b1100.
